// File: rtl/or_gate_pkg.sv
// ---------------------------------------------------------------------------
// or_gate_pkg
//   Shared definitions for the three-input OR gate and its synchronizer
//   chains: default parameter values, the all-ones counter limit at the
//   default width, and the packed struct that carries the edge-pulse flags.
// ---------------------------------------------------------------------------
package or_gate_pkg;

    // Default number of flip-flops in each input synchronizer (legal 1..4).
    localparam int SYNC_STAGES_DEFAULT = 2;

    // Default width of the saturating high-cycle counter.
    localparam int CNT_W_DEFAULT = 16;

    // Saturation value of the counter at the default width.
    localparam logic [CNT_W_DEFAULT-1:0] CNT_MAX = {CNT_W_DEFAULT{1'b1}};

    // Registered edge pulses derived from d_q.
    typedef struct packed {
        logic rise;
        logic fall;
    } edge_flags_t;

endpackage : or_gate_pkg

// File: rtl/sync_ff_chain.sv
// ---------------------------------------------------------------------------
// sync_ff_chain
//   Multi-stage flip-flop synchronizer for one asynchronous single-bit input.
//   dout follows din after STAGES rising edges of clk.
//
// Ports:
//   clk   in   system clock, rising-edge active
//   rst   in   synchronous active-high reset; clears every stage to 0
//   din   in   asynchronous input bit
//   dout  out  synchronized copy of din (last stage of the chain)
// ---------------------------------------------------------------------------
module sync_ff_chain
    import or_gate_pkg::*;
#(
    parameter int STAGES = SYNC_STAGES_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout
);

    logic [STAGES-1:0] chain;

    // Written as a per-bit loop so that STAGES == 1 needs no special case.
    always_ff @(posedge clk) begin
        if (rst) begin
            chain <= '0;
        end else begin
            chain[0] <= din;
            for (int i = 1; i < STAGES; i++) begin
                chain[i] <= chain[i-1];
            end
        end
    end

    assign dout = chain[STAGES-1];

endmodule : sync_ff_chain

// File: rtl/three_input_or_gate_a.sv
// ---------------------------------------------------------------------------
// three_input_or_gate_a
//   Three-input OR gate. The primary output d is purely combinational and
//   works with no clock and during reset. A companion clocked path
//   synchronizes the inputs into the clk domain, registers their OR (d_q),
//   flags its rising and falling edges and counts the cycles it is high.
//
// Ports:
//   clk       in   system clock, rising-edge active
//   rst       in   synchronous active-high reset for the clocked path
//   a, b, c   in   OR operands, asynchronous to clk
//   d         out  a | b | c, zero latency
//   d_q       out  registered OR of the synchronized inputs
//                  (SYNC_STAGES+1 edges after an input change)
//   d_rise    out  one-cycle pulse, the cycle after d_q goes 0->1
//   d_fall    out  one-cycle pulse, the cycle after d_q goes 1->0
//   high_cnt  out  cycles d_q has been 1 since reset, saturating at all-ones
// ---------------------------------------------------------------------------
module three_input_or_gate_a
    import or_gate_pkg::*;
#(
    parameter int SYNC_STAGES = SYNC_STAGES_DEFAULT,
    parameter int CNT_W       = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             a,
    input  logic             b,
    input  logic             c,
    output logic             d,
    output logic             d_q,
    output logic             d_rise,
    output logic             d_fall,
    output logic [CNT_W-1:0] high_cnt
);

    localparam logic [CNT_W-1:0] CNT_LIMIT = {CNT_W{1'b1}};

    // ------------------------------------------------------------------
    // Combinational path: no dependency on clk or rst.
    // ------------------------------------------------------------------
    assign d = a | b | c;

    // ------------------------------------------------------------------
    // Input synchronizers. Each input gets its own chain; skew between
    // the chains is harmless because only their OR is consumed.
    // ------------------------------------------------------------------
    logic a_s;
    logic b_s;
    logic c_s;

    sync_ff_chain #(.STAGES(SYNC_STAGES)) u_sync_a (
        .clk  (clk),
        .rst  (rst),
        .din  (a),
        .dout (a_s)
    );

    sync_ff_chain #(.STAGES(SYNC_STAGES)) u_sync_b (
        .clk  (clk),
        .rst  (rst),
        .din  (b),
        .dout (b_s)
    );

    sync_ff_chain #(.STAGES(SYNC_STAGES)) u_sync_c (
        .clk  (clk),
        .rst  (rst),
        .din  (c),
        .dout (c_s)
    );

    // ------------------------------------------------------------------
    // Registered OR, edge detection and saturating counter.
    // d_q_prev lags d_q by one edge, so the edge flags and the counter
    // all describe the d_q value of the previous cycle.
    // ------------------------------------------------------------------
    logic        d_q_prev;
    edge_flags_t edges;

    always_ff @(posedge clk) begin
        if (rst) begin
            d_q      <= 1'b0;
            d_q_prev <= 1'b0;
            edges    <= '0;
            high_cnt <= '0;
        end else begin
            d_q        <= a_s | b_s | c_s;
            d_q_prev   <= d_q;
            edges.rise <= d_q & ~d_q_prev;
            edges.fall <= ~d_q & d_q_prev;
            if (d_q && (high_cnt != CNT_LIMIT)) begin
                high_cnt <= high_cnt + CNT_W'(1);
            end
        end
    end

    assign d_rise = edges.rise;
    assign d_fall = edges.fall;

endmodule : three_input_or_gate_a

// File: tb/tb_three_input_or_gate_a.sv
module tb_three_input_or_gate_a;

  localparam int SYNC = 2;

  logic clk = 1'b0;
  bit   clk_en = 1'b1;
  logic rst = 1'b1;
  logic a = 1'b0;
  logic b = 1'b0;
  logic c = 1'b0;

  logic        d, d_q, d_rise, d_fall;
  logic [15:0] high_cnt;
  logic        d4, dq4, rise4, fall4;
  logic [3:0]  cnt4;

  int n_cmp = 0;
  int n_err = 0;

  // ---------------- clock / reset ----------------
  always #5 if (clk_en) clk = ~clk;

  three_input_or_gate_a #(.SYNC_STAGES(SYNC), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .a(a), .b(b), .c(c),
    .d(d), .d_q(d_q), .d_rise(d_rise), .d_fall(d_fall), .high_cnt(high_cnt)
  );

  three_input_or_gate_a #(.SYNC_STAGES(SYNC), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .a(a), .b(b), .c(c),
    .d(d4), .d_q(dq4), .d_rise(rise4), .d_fall(fall4), .high_cnt(cnt4)
  );

  // ---------------- reference model ----------------
  // The clocked OR is the input OR as it was SYNC edges earlier; edge flags
  // and the count describe d_q one cycle late.
  bit          hist_q[$];
  bit          m_dq, m_prev, m_rise, m_fall;
  int unsigned m_cnt, m_cnt4;

  always @(posedge clk) begin
    bit old_dq;
    if (rst) begin
      hist_q = {};
      for (int i = 0; i < SYNC; i++) hist_q.push_back(1'b0);
      m_dq = 0; m_prev = 0; m_rise = 0; m_fall = 0; m_cnt = 0; m_cnt4 = 0;
    end else begin
      old_dq = m_dq;
      m_rise = old_dq && !m_prev;
      m_fall = !old_dq && m_prev;
      m_prev = old_dq;
      if (old_dq) begin
        if (m_cnt < 65535) m_cnt = m_cnt + 1;
        if (m_cnt4 < 15) m_cnt4 = m_cnt4 + 1;
      end
      m_dq = (hist_q.size() > 0) ? hist_q.pop_front() : 1'b0;
      hist_q.push_back(a | b | c);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1; a = 0; b = 0; c = 0;
    tick();
    tick();
    n_cmp++;
    if ({d_q, d_rise, d_fall, high_cnt} !== 19'd0) begin
      n_err++;
      $display("FAIL reset_main: dq=%b rise=%b fall=%b cnt=%0d, required all 0", d_q, d_rise, d_fall, high_cnt);
    end
    n_cmp++;
    if ({dq4, rise4, fall4, cnt4} !== 7'd0) begin
      n_err++;
      $display("FAIL reset_cnt4: dq=%b rise=%b fall=%b cnt=%0d, required all 0", dq4, rise4, fall4, cnt4);
    end
    rst = 1'b0;
  endtask

  // mode 0: clock running, rst low; 1: rst held high; 2: clock stopped
  task automatic test_comb();
    for (int mode = 0; mode < 3; mode++) begin
      rst = (mode == 1);
      if (mode == 2) begin
        @(negedge clk);
        clk_en = 1'b0;
      end
      for (int i = 0; i < 8; i++) begin
        logic [2:0] abc;
        abc = i[2:0];
        {a, b, c} = abc;
        #0;
        n_cmp++;
        if (d !== (i != 0)) begin
          n_err++;
          $display("FAIL comb_m%0d_abc%0d: d=%b, required %b", mode, i, d, (i != 0));
        end
        #2;
      end
      clk_en = 1'b1;
      {a, b, c} = 3'b000;
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_latency();
    do_reset();
    {a, b, c} = 3'b000;
    tick();
    tick();
    b = 1'b1;
    #0;
    n_cmp++;
    if (d !== 1'b1) begin
      n_err++;
      $display("FAIL latency_d: d=%b, required 1", d);
    end
    for (int k = 1; k <= 6; k++) begin
      tick();
      n_cmp++;
      if (d_q !== (k >= 3) || d_rise !== (k == 4) || d_fall !== 1'b0) begin
        n_err++;
        $display("FAIL latency_edge%0d: dq=%b rise=%b fall=%b, required dq=%b rise=%b fall=0",
                 k, d_q, d_rise, d_fall, (k >= 3), (k == 4));
      end
    end
    b = 1'b0;
  endtask

  task automatic test_edge_count();
    int rises = 0;
    int falls = 0;
    do_reset();
    {a, b, c} = 3'b000;
    tick();
    a = 1'b1;
    for (int k = 0; k < 18; k++) begin
      tick();
      if (k == 9) a = 1'b0;
      rises += int'(d_rise);
      falls += int'(d_fall);
    end
    n_cmp++;
    if (high_cnt !== 16'd10) begin
      n_err++;
      $display("FAIL edge_count_cnt: cnt=%0d, required 10", high_cnt);
    end
    n_cmp++;
    if (rises != 1 || falls != 1) begin
      n_err++;
      $display("FAIL edge_count_pulses: rises=%0d falls=%0d, required 1 and 1", rises, falls);
    end
  endtask

  task automatic test_saturation();
    int exp_cnt;
    do_reset();
    {a, b, c} = 3'b001;
    for (int i = 1; i <= 40; i++) begin
      tick();
      exp_cnt = (i > 3) ? i - 3 : 0;
      if (exp_cnt > 15) exp_cnt = 15;
      if (i % 4 == 0 || i >= 36) begin
        n_cmp++;
        if (cnt4 !== 4'(exp_cnt)) begin
          n_err++;
          $display("FAIL saturation_t%0d: cnt4=%0d, required %0d", i, cnt4, exp_cnt);
        end
      end
    end
    c = 1'b0;
  endtask

  task automatic test_mid_reset();
    bit reached = 0;
    do_reset();
    {a, b, c} = 3'b100;
    for (int i = 0; i < 40 && !reached; i++) begin
      tick();
      if (m_cnt == 7 && m_dq) reached = 1;
    end
    n_cmp++;
    if (!reached || high_cnt !== 16'd7 || d_q !== 1'b1) begin
      n_err++;
      $display("FAIL mid_reset_setup: dq=%b cnt=%0d, required dq=1 cnt=7", d_q, high_cnt);
    end
    rst = 1'b1;
    tick();
    n_cmp++;
    if (d_q !== 1'b0 || high_cnt !== 16'd0 || d_rise !== 1'b0 || d_fall !== 1'b0 || d !== 1'b1) begin
      n_err++;
      $display("FAIL mid_reset_clear: dq=%b cnt=%0d rise=%b fall=%b d=%b, required 0 0 0 0 1",
               d_q, high_cnt, d_rise, d_fall, d);
    end
    rst = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      tick();
      n_cmp++;
      if (d_q !== (k >= 3) || d_rise !== (k == 4) || d_fall !== 1'b0 || d !== 1'b1) begin
        n_err++;
        $display("FAIL mid_reset_reacq%0d: dq=%b rise=%b fall=%b d=%b, required dq=%b rise=%b fall=0 d=1",
                 k, d_q, d_rise, d_fall, d, (k >= 3), (k == 4));
      end
    end
    a = 1'b0;
  endtask

  task automatic test_short_pulse();
    do_reset();
    {a, b, c} = 3'b000;
    for (int i = 0; i < 4; i++) tick();
    a = 1'b1;
    tick();
    a = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      n_cmp++;
      if (d_q !== (k == 2) || d_rise !== (k == 3) || d_fall !== (k == 4) ||
          high_cnt !== ((k >= 3) ? 16'd1 : 16'd0)) begin
        n_err++;
        $display("FAIL short_pulse_t%0d: dq=%b rise=%b fall=%b cnt=%0d, required dq=%b rise=%b fall=%b cnt=%0d",
                 k, d_q, d_rise, d_fall, high_cnt, (k == 2), (k == 3), (k == 4), (k >= 3));
      end
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 49) == 0);
      if ($urandom_range(0, 3) == 0) {a, b, c} = 3'($urandom_range(0, 7));
      tick();
      n_cmp++;
      if (d !== (a | b | c) || d_q !== m_dq || d_rise !== m_rise || d_fall !== m_fall ||
          high_cnt !== 16'(m_cnt)) begin
        n_err++;
        $display("FAIL random_t%0d: d=%b dq=%b rise=%b fall=%b cnt=%0d, required d=%b dq=%b rise=%b fall=%b cnt=%0d",
                 i, d, d_q, d_rise, d_fall, high_cnt, (a | b | c), m_dq, m_rise, m_fall, m_cnt);
      end
      n_cmp++;
      if (dq4 !== m_dq || rise4 !== m_rise || fall4 !== m_fall || cnt4 !== 4'(m_cnt4)) begin
        n_err++;
        $display("FAIL random4_t%0d: dq=%b rise=%b fall=%b cnt=%0d, required dq=%b rise=%b fall=%b cnt=%0d",
                 i, dq4, rise4, fall4, cnt4, m_dq, m_rise, m_fall, m_cnt4);
      end
    end
    rst = 1'b0;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_comb();
    test_latency();
    test_edge_count();
    test_saturation();
    test_mid_reset();
    test_short_pulse();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_three_input_or_gate_a

// File: doc/three_input_or_gate_a.md
Name: three_input_or_gate_a

Overview:
- Three-input OR gate with a combinational output `d` and a clocked, synchronized companion path.
- The combinational path is the primary function: `d = a | b | c` at zero latency.
- The clocked path adds the following, for use by downstream synchronous logic in the clk domain:
  - synchronizes the asynchronous inputs;
  - registers the OR result;
  - flags its edges;
  - counts the cycles it is asserted.

Parameters:
- SYNC_STAGES, 2, number of flip-flop synchronizer stages per input (legal range 1..4).
- CNT_W, 16, width of the saturating high-cycle counter.

Ports:
- clk  input  1  system clock; all registers update on its rising edge.
- rst  input  1  synchronous, active-high reset.
- a  input  1  OR operand; asynchronous to clk.
- b  input  1  OR operand; asynchronous to clk.
- c  input  1  OR operand; asynchronous to clk.
- d  output  1  combinational `a | b | c`.
- d_q  output  1  registered OR of the synchronized inputs.
- d_rise  output  1  one-cycle pulse when d_q goes 0->1.
- d_fall  output  1  one-cycle pulse when d_q goes 1->0.
- high_cnt  output  CNT_W  number of cycles d_q has been 1 since reset; saturating.

Behaviour:
- Combinational output `d`:
  - `d = a | b | c`, purely combinational, with no clock or reset dependency.
  - `d` is valid with no clock running and while rst is asserted.
  - Truth table: `d` is 0 only for a=b=c=0; it is 1 for the other 7 combinations.
- Synchronizers:
  - Each of a, b, c passes through its own SYNC_STAGES-deep flip-flop chain, giving a_s, b_s, c_s.
  - The chains reset to 0.
- `d_q`:
  - Registered `a_s | b_s | c_s`.
  - Latency from an input change to `d_q` is SYNC_STAGES+1 rising edges (3 at default).
- Edge pulses:
  - An internal register d_q_prev holds the previous value of `d_q`.
  - `d_rise = d_q & ~d_q_prev`; `d_fall = ~d_q & d_q_prev`. Both are registered outputs, valid one cycle after the corresponding `d_q` edge, and each lasts exactly one cycle.
  - A single-cycle `d_q` pulse produces `d_rise` in one cycle followed by `d_fall` in the next.
- `high_cnt`:
  - Increments by 1 on every cycle in which `d_q` == 1.
  - Holds at 2^CNT_W-1; it never wraps.
- Reset:
  - While rst == 1 at a rising edge, all of the following go to 0 on that edge: synchronizer flops, d_q, d_q_prev, d_rise, d_fall, high_cnt.
  - Reset asserted mid-operation overrides everything in the same cycle.
  - After rst is released, the clocked path re-acquires the inputs with the normal SYNC_STAGES+1 latency. No spurious `d_rise` occurs unless the synchronized OR is 1.
- Simultaneous input changes:
  - `d` tracks all three immediately.
  - The clocked path sees them after synchronization. Multi-bit skew between chains is tolerated because only the OR is consumed.
- Input glitches:
  - A glitch shorter than one clk period may be missed by `d_q`.
  - `d` always reflects it.

Decomposition:
- Shared package `or_gate_pkg`:
  - SYNC_STAGES_DEFAULT = 2
  - CNT_W_DEFAULT = 16
  - localparam CNT_MAX = {CNT_W{1'b1}}
- One sub-module: `sync_ff_chain`:
  - parameter STAGES;
  - ports clk, rst, din, dout;
  - synchronous active-high reset to 0;
  - instantiated three times.
- The top level holds the combinational OR, d_q, the edge logic and the counter.

Test Plan:
- Exhaustive combinational check:
  - stimulus: a toggles every 8 ns, b every 4 ns, c every 2 ns, from 000;
  - required: `d` == 0 only when abc == 000, 1 for the other 7 combinations, with zero delay;
  - also required with clk stopped and with rst held at 1.
- Latency:
  - stimulus: after reset with abc = 000, set b = 1 just after a rising edge;
  - required: `d` = 1 immediately; `d_q` = 1 on the 3rd rising edge; `d_rise` = 1 for exactly the following cycle; `d_fall` stays 0.
- Edge and count:
  - stimulus: hold a = 1 for 10 cycles (as seen at `d_q`), then abc = 000;
  - required: `high_cnt` = 10; exactly one `d_rise` and one `d_fall` pulse.
- Saturation:
  - stimulus: CNT_W = 4, hold c = 1 for 40 cycles;
  - required: `high_cnt` reaches 15 and stays at 15.
- Mid-operation reset:
  - stimulus: with `d_q` = 1 and `high_cnt` = 7, assert rst for 1 cycle while a = 1;
  - required: the next edge gives `d_q` = 0, `high_cnt` = 0 and `d_rise`/`d_fall` = 0; `d` stays 1 throughout; `d_q` returns to 1 three edges after rst deasserts, followed by one `d_rise`.
- Short pulse:
  - stimulus: 1-cycle pulse on a, aligned to be captured;
  - required: `d_q` is high for 1 cycle; `d_rise` and `d_fall` appear on consecutive cycles; `high_cnt` increments by 1.
